ps2_keycode: RTL and testbench

PS2_KEYCODE -- requirements
Module: ps2_keycode

---
 rtl/ps2_pkg.sv | 52 +++++
 rtl/ps2_frame_rx.sv | 127 ++++++++++++
 rtl/ps2_keycode.sv | 74 +++++++
 tb/tb_ps2_keycode.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame FSM states,
// scan-code prefixes, HID usage codes and the scan-to-HID lookup.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;

  // 0x00 means "not a key the player-motion logic cares about".
  function automatic logic [7:0] map_scan(input logic ext, input logic [7:0] scan);
    logic [7:0] hid;
    hid = 8'h00;
    if (ext) begin
      case (scan)
        8'h75:   hid = KEY_UP;
        8'h72:   hid = KEY_DOWN;
        8'h6B:   hid = KEY_LEFT;
        8'h74:   hid = KEY_RIGHT;
        default: hid = 8'h00;
      endcase
    end else begin
      case (scan)
        8'h1C:   hid = KEY_A;
        8'h23:   hid = KEY_D;
        8'h1B:   hid = KEY_S;
        8'h1D:   hid = KEY_W;
        8'h29:   hid = KEY_SPACE;
        8'h5A:   hid = KEY_ENTER;
        default: hid = 8'h00;
      endcase
    end
    return hid;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw bus, detects falling clock edges and
// assembles 11-bit frames into bytes, reporting parity/stop/timeout failures.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_done,
  output logic       frame_err,
  output logic       timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_TERM = TW'(TIMEOUT_CYCLES);

  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic fall;

  frame_state_t  state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          parity_odd, parity_odd_n;
  logic [TW-1:0] timer, timer_n;
  logic          byte_done_n, frame_err_n, timeout_n;

  // Synchronizers idle high so a reset never manufactures a falling edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      parity_odd <= 1'b0;
      timer      <= '0;
      byte_done  <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      parity_odd <= parity_odd_n;
      timer      <= timer_n;
      byte_done  <= byte_done_n;
      frame_err  <= frame_err_n;
      timeout    <= timeout_n;
    end
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    parity_odd_n = parity_odd;
    timer_n      = timer;
    byte_done_n  = 1'b0;
    frame_err_n  = 1'b0;
    timeout_n    = 1'b0;

    if (state != IDLE) timer_n = timer + 1'b1;

    // An edge landing on the terminal count keeps the frame alive.
    if (fall) begin
      timer_n = '0;
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
          end else begin
            frame_err_n = 1'b1;
          end
        end
        DATA: begin
          shift_n   = {dat_s2, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          parity_odd_n = ^{shift, dat_s2};
          state_n      = STOP;
        end
        STOP: begin
          if (dat_s2 && parity_odd) byte_done_n = 1'b1;
          else                      frame_err_n = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && timer == TIMER_TERM) begin
      state_n     = IDLE;
      timer_n     = '0;
      bit_cnt_n   = 3'd0;
      shift_n     = 8'h00;
      frame_err_n = 1'b1;
      timeout_n   = 1'b1;
    end
  end

  // The shift register is stable from the stop edge onward, so it doubles as
  // the byte output while byte_done is high.
  assign data_byte = shift;

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard front end: turns received scan-code bytes into the HID code of
// the currently held movement key, tracking E0/F0 prefixes across bytes.
module ps2_keycode
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] data_byte;
  logic       byte_done;
  logic       timeout;
  logic       ext, brk;
  logic [7:0] mapped;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_byte (data_byte),
    .byte_done (byte_done),
    .frame_err (frame_err),
    .timeout   (timeout)
  );

  always_comb mapped = map_scan(ext, data_byte);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      keycode   <= 8'h00;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (timeout) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_done) begin
        if (data_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else if (data_byte == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          // Only releasing the held key clears it; typematic repeats are silent.
          if (mapped != 8'h00) begin
            if (brk) begin
              if (mapped == keycode) begin
                keycode   <= 8'h00;
                key_valid <= 1'b1;
              end
            end else if (mapped != keycode) begin
              keycode   <= mapped;
              key_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode.sv
// Self-checking bench for ps2_keycode: directed scenarios plus random scan-code
// traffic compared against a scan-code level behavioural model.
module tb_ps2_keycode;

  localparam int TO   = 200;
  localparam int HALF = 10;
  localparam int GAP  = 30;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  ps2_keycode #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  int         err_seen = 0;
  int         exp_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mdl_kc = 8'h00;
  bit         mdl_ext = 1'b0;
  bit         mdl_brk = 1'b0;
  logic [7:0] prev_kc = 8'h00;

  logic [7:0] ne_scan[6] = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29, 8'h5A};
  logic [7:0] ne_hid [6] = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C, 8'h28};
  logic [7:0] ex_scan[4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
  logic [7:0] ex_hid [4] = '{8'h52, 8'h51, 8'h50, 8'h4F};
  logic [7:0] pool[14] = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29, 8'h5A, 8'h75,
                           8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'h12, 8'h33};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lookup(input bit e, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    if (e) begin
      for (int i = 0; i < 4; i++) if (ex_scan[i] == b) r = ex_hid[i];
    end else begin
      for (int i = 0; i < 6; i++) if (ne_scan[i] == b) r = ne_hid[i];
    end
    return r;
  endfunction

  // Behavioural model of one accepted byte: prefixes latch, anything else
  // resolves make/break against the held key and drops the prefixes.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] code;
    if (b == 8'hE0) begin
      mdl_ext = 1'b1;
    end else if (b == 8'hF0) begin
      mdl_brk = 1'b1;
    end else begin
      code = lookup(mdl_ext, b);
      if (code != 8'h00) begin
        if (mdl_brk && code == mdl_kc) begin
          mdl_kc = 8'h00;
          exp_q.push_back(mdl_kc);
        end else if (!mdl_brk && code != mdl_kc) begin
          mdl_kc = code;
          exp_q.push_back(mdl_kc);
        end
      end
      mdl_ext = 1'b0;
      mdl_brk = 1'b0;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prev_kc = 8'h00;
      end else begin
        check("key_valid_vs_change", key_valid, keycode != prev_kc);
        if (key_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key_valid: got keycode 0x%0h expected no pulse at %0t",
                     keycode, $time);
          end else begin
            e = exp_q.pop_front();
            check("key_valid_value", keycode, e);
          end
        end
        if (frame_err) err_seen++;
        prev_kc = keycode;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic ps2_bit(input logic v);
    @(negedge Clk);
    ps2_data = v;
    repeat (HALF) @(negedge Clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge Clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_parity);
    logic p;
    p = ~(^b) ^ bad_parity;
    if (bad_parity) exp_err++;
    else            model_byte(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    repeat (GAP) @(negedge Clk);
  endtask

  task automatic start_partial(input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
    @(negedge Clk);
    ps2_data = 1'b1;
  endtask

  task automatic partial_frame(input int nbits);
    start_partial(nbits);
    exp_err++;
    mdl_ext = 1'b0;
    mdl_brk = 1'b0;
    repeat (TO + GAP) @(negedge Clk);
  endtask

  task automatic frame_end_checks();
    check("frame_err_count", err_seen, exp_err);
    check("keycode_model", keycode, mdl_kc);
  endtask

  task automatic apply_reset();
    @(posedge Clk);
    #2 Reset = 1'b1;
    exp_q.delete();
    mdl_kc  = 8'h00;
    mdl_ext = 1'b0;
    mdl_brk = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset_keycode", keycode, 8'h00);
    check("reset_key_valid", key_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    @(posedge Clk);
    #2 Reset = 1'b0;
    repeat (GAP) @(negedge Clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    apply_reset();

    send_frame(8'h1C, 1'b0);
    check("a_make_keycode", keycode, 8'h04);
    check("a_make_no_err", err_seen, 0);
    frame_end_checks();

    send_frame(8'h1C, 1'b0);
    check("a_typematic_keycode", keycode, 8'h04);
    send_frame(8'hF0, 1'b0);
    check("brk_prefix_no_change", keycode, 8'h04);
    send_frame(8'h1C, 1'b0);
    check("a_break_keycode", keycode, 8'h00);
    frame_end_checks();

    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("up_make_keycode", keycode, 8'h52);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("up_break_keycode", keycode, 8'h00);
    send_frame(8'h75, 1'b0);
    check("plain_75_no_change", keycode, 8'h00);
    frame_end_checks();

    send_frame(8'h23, 1'b1);
    check("bad_parity_err", err_seen, 1);
    check("bad_parity_keycode", keycode, 8'h00);

    partial_frame(4);
    check("timeout_err", err_seen, 2);
    send_frame(8'h1D, 1'b0);
    check("w_after_timeout", keycode, 8'h1A);

    send_frame(8'hE0, 1'b0);
    partial_frame(3);
    send_frame(8'h75, 1'b0);
    check("timeout_clears_ext", keycode, 8'h1A);
    frame_end_checks();

    start_partial(4);
    apply_reset();
    check("reset_midframe_no_err", err_seen, exp_err);
    send_frame(8'h1B, 1'b0);
    check("s_after_reset", keycode, 8'h16);
    frame_end_checks();

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0) partial_frame($urandom_range(0, 9));
      else        send_frame(pool[$urandom_range(0, 13)], r == 1);
      frame_end_checks();
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
